// File: rtl/breath_pwm_pkg.sv
// Shared definitions for the breathing-PWM sequencer.
// Contents: state encoding, duty limits, PWM width and saturating duty arithmetic helpers.
package breath_pwm_pkg;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] UP      = 3'd1;
   localparam logic [2:0] HOLD_HI = 3'd2;
   localparam logic [2:0] DOWN    = 3'd3;
   localparam logic [2:0] HOLD_LO = 3'd4;

   typedef enum logic [2:0] {
      StIdle   = IDLE,
      StUp     = UP,
      StHoldHi = HOLD_HI,
      StDown   = DOWN,
      StHoldLo = HOLD_LO
   } state_e;

   localparam int unsigned PWM_W    = 8;
   localparam logic [7:0]  DUTY_MAX = 8'd255;

   // 9-bit sum so the carry detects overflow; saturate at DUTY_MAX.
   function automatic logic [7:0] duty_sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? DUTY_MAX : sum[7:0];
   endfunction

   // Clamp at zero instead of wrapping.
   function automatic logic [7:0] duty_sat_sub(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : 8'd0;
   endfunction

endpackage

// File: rtl/breath_pwm_ctrl_pwm_compare.sv
// Glitch-free PWM comparator.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   duty       : requested duty (may change at any time)
//   pwm_out    : registered pin drive, high for duty_act of every 256 clk
// The requested duty is only adopted at the period boundary so a period never
// mixes two duty values.
module pwm_compare
   import breath_pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PWM_W-1:0] duty,
   output logic             pwm_out
);

   logic [PWM_W-1:0] pcnt_q;
   logic [PWM_W-1:0] duty_act_q;
   logic             pwm_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt_q     <= '0;
         duty_act_q <= '0;
         pwm_q      <= 1'b0;
      end else begin
         pcnt_q <= pcnt_q + PWM_W'(1);
         if (pcnt_q == '1) begin
            duty_act_q <= duty;
         end
         pwm_q <= (pcnt_q < duty_act_q);
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: rtl/breath_pwm_ctrl.sv
// Breathing triangle-duty sequencer with PWM output.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, stop         : one-cycle control pulses (stop wins)
//   div                 : ramp tick every div+1 clk
//   step                : duty change per tick (0 behaves as 1)
//   hold_hi, hold_lo    : dwell ticks at 255 / at 0
//   cycles              : up/down cycles to run, 0 = until stop
//   duty, pwm_out       : sequenced duty and pin drive
//   busy, done, phase   : status; done pulses when the cycle count completes
module breath_pwm_ctrl
   import breath_pwm_pkg::*;
#(
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned HOLD_W = 8,
   parameter int unsigned CYC_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [DIV_W-1:0]  div,
   input  logic [7:0]        step,
   input  logic [HOLD_W-1:0] hold_hi,
   input  logic [HOLD_W-1:0] hold_lo,
   input  logic [CYC_W-1:0]  cycles,
   output logic [7:0]        duty,
   output logic              pwm_out,
   output logic              busy,
   output logic              done,
   output logic [2:0]        phase
);

   state_e            state_q, state_d;
   logic [7:0]        duty_q, duty_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic              done_q, done_d;
   logic [DIV_W-1:0]  presc_q;

   logic [DIV_W-1:0]  div_l;
   logic [7:0]        step_l;
   logic [HOLD_W-1:0] hold_hi_l, hold_lo_l;
   logic [CYC_W-1:0]  cycles_l;

   logic accept;
   logic tick;

   assign accept = (state_q == StIdle) && start && !stop;
   assign tick   = (state_q != StIdle) && (presc_q == div_l);

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      cyc_d   = cyc_q;
      done_d  = 1'b0;
      if (state_q != StIdle && stop) begin
         state_d = StIdle;
         duty_d  = 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_d = StUp;
                  duty_d  = 8'd0;
                  cyc_d   = '0;
                  hold_d  = '0;
               end
            end
            StUp: begin
               if (tick) begin
                  duty_d = duty_sat_add(duty_q, step_l);
                  if (duty_d == DUTY_MAX) begin
                     state_d = StHoldHi;
                     hold_d  = '0;
                  end
               end
            end
            StHoldHi: begin
               if (tick) begin
                  hold_d = hold_q + HOLD_W'(1);
                  if (hold_q == hold_hi_l) begin
                     state_d = StDown;
                  end
               end
            end
            StDown: begin
               if (tick) begin
                  duty_d = duty_sat_sub(duty_q, step_l);
                  if (duty_d == 8'd0) begin
                     state_d = StHoldLo;
                     hold_d  = '0;
                  end
               end
            end
            StHoldLo: begin
               if (tick) begin
                  hold_d = hold_q + HOLD_W'(1);
                  if (hold_q == hold_lo_l) begin
                     cyc_d = cyc_q + CYC_W'(1);
                     // cycles_l == 0 lets the counter wrap forever.
                     if (cycles_l != '0 && cyc_d == cycles_l) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                     end else begin
                        state_d = StUp;
                     end
                  end
               end
            end
            default: begin
               state_d = StIdle;
               duty_d  = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         duty_q    <= 8'd0;
         hold_q    <= '0;
         cyc_q     <= '0;
         done_q    <= 1'b0;
         presc_q   <= '0;
         div_l     <= '0;
         step_l    <= 8'd1;
         hold_hi_l <= '0;
         hold_lo_l <= '0;
         cycles_l  <= '0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
         cyc_q   <= cyc_d;
         done_q  <= done_d;
         // Prescaler is held at zero while idle and cleared on the way back to idle.
         if (state_q == StIdle || state_d == StIdle) begin
            presc_q <= '0;
         end else if (tick) begin
            presc_q <= '0;
         end else begin
            presc_q <= presc_q + DIV_W'(1);
         end
         if (accept) begin
            div_l     <= div;
            step_l    <= (step == 8'd0) ? 8'd1 : step;
            hold_hi_l <= hold_hi;
            hold_lo_l <= hold_lo;
            cycles_l  <= cycles;
         end
      end
   end

   pwm_compare u_pwm_compare (
      .clk     (clk),
      .rst_n   (rst_n),
      .duty    (duty_q),
      .pwm_out (pwm_out)
   );

   assign duty  = duty_q;
   assign busy  = (state_q != StIdle);
   assign done  = done_q;
   assign phase = state_q;

endmodule

// File: tb/tb_breath_pwm_ctrl.sv
// Scoreboard bench for breath_pwm_ctrl: the stimulus side derives the per-cycle
// expected {duty, phase, busy, done} from the ramp rules and queues it; the
// monitor pops one entry per clock and also models the PWM pin from expected duty.
module tb_breath_pwm_ctrl;

   localparam int PH_IDLE = 0;
   localparam int PH_UP   = 1;
   localparam int PH_HH   = 2;
   localparam int PH_DN   = 3;
   localparam int PH_HL   = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] div = '0;
   logic [7:0]  step = '0;
   logic [7:0]  hold_hi = '0;
   logic [7:0]  hold_lo = '0;
   logic [7:0]  cycles = '0;
   logic [7:0]  duty;
   logic        pwm_out;
   logic        busy;
   logic        done;
   logic [2:0]  phase;

   breath_pwm_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .div     (div),
      .step    (step),
      .hold_hi (hold_hi),
      .hold_lo (hold_lo),
      .cycles  (cycles),
      .duty    (duty),
      .pwm_out (pwm_out),
      .busy    (busy),
      .done    (done),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d;
      int ph;
      int b;
      int dn;
   } exp_t;

   exp_t expq[$];
   exp_t ticks[$];
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t mk(input int d, input int ph, input int b, input int dn);
      exp_t e;
      e.d = d; e.ph = ph; e.b = b; e.dn = dn;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
      end
   endtask

   // State after each ramp tick, from the triangle rules: index 0 is right after start.
   task automatic gen_ticks(input int st, input int hh, input int hl, input int cy);
      int s;
      int d;
      int ncyc;
      ticks.delete();
      s    = (st == 0) ? 1 : st;
      d    = 0;
      ncyc = (cy == 0) ? 4 : cy;
      ticks.push_back(mk(0, PH_UP, 1, 0));
      for (int c = 1; c <= ncyc; c++) begin
         do begin
            d = (d + s > 255) ? 255 : d + s;
            ticks.push_back(mk(d, (d == 255) ? PH_HH : PH_UP, 1, 0));
         end while (d < 255);
         repeat (hh) ticks.push_back(mk(255, PH_HH, 1, 0));
         ticks.push_back(mk(255, PH_DN, 1, 0));
         do begin
            d = (d - s < 0) ? 0 : d - s;
            ticks.push_back(mk(d, (d == 0) ? PH_HL : PH_DN, 1, 0));
         end while (d > 0);
         repeat (hl) ticks.push_back(mk(0, PH_HL, 1, 0));
         if (cy != 0 && c == cy) ticks.push_back(mk(0, PH_IDLE, 0, 1));
         else ticks.push_back(mk(0, PH_UP, 1, 0));
      end
   endtask

   // stop_at / rst_at: cycle index after start where the abort edge lands (-1 none, -2 random).
   task automatic run(input int dv, input int st, input int hh, input int hl, input int cy,
                      input int stop_at_in, input int rst_at, input bit with_start);
      exp_t lst[$];
      int   stop_at;
      int   cut;
      int   budget;
      gen_ticks(st, hh, hl, cy);
      for (int t = 0; t < ticks.size(); t++) begin
         if (ticks[t].b == 0) lst.push_back(ticks[t]);
         else repeat (dv + 1) lst.push_back(ticks[t]);
      end
      stop_at = (stop_at_in == -2) ? int'($urandom_range(1, lst.size() - 2)) : stop_at_in;
      cut = (stop_at >= 0) ? stop_at : rst_at;
      if (cut >= 0) begin
         while (lst.size() > cut) void'(lst.pop_back());
         lst.push_back(mk(0, PH_IDLE, 0, 0));
      end
      div = 16'(dv); step = 8'(st); hold_hi = 8'(hh); hold_lo = 8'(hl); cycles = 8'(cy);
      start = 1'b1;
      @(posedge clk);
      foreach (lst[i]) expq.push_back(lst[i]);
      budget = lst.size() + 50;
      #1;
      start = 1'b0;
      // Config changes while busy must be ignored.
      div = 16'($urandom); step = 8'($urandom); hold_hi = 8'($urandom);
      hold_lo = 8'($urandom); cycles = 8'($urandom);
      if (cut >= 0) begin
         repeat (cut - 1) @(posedge clk);
         #1;
         if (stop_at >= 0) begin
            stop = 1'b1;
            start = with_start;
         end else begin
            rst_n = 1'b0;
         end
         @(posedge clk);
         #1;
         stop = 1'b0; start = 1'b0; rst_n = 1'b1;
      end
      for (int i = 0; i < budget && expq.size() > 0; i++) @(posedge clk);
      if (expq.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d entries left expected 0", expq.size());
         expq.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: one expected entry per clock; idle values when the queue is empty.
   initial begin
      exp_t e;
      logic r;
      int   n = 0;
      int   act = 0;
      int   prev = 0;
      int   dprev = 0;
      int   ep = 0;
      forever begin
         @(posedge clk);
         r = rst_n;
         @(negedge clk);
         if (expq.size() > 0) e = expq.pop_front();
         else e = mk(0, PH_IDLE, 0, 0);
         chk("duty", 32'(duty), 32'(e.d));
         chk("phase", 32'(phase), 32'(e.ph));
         chk("busy", 32'(busy), 32'(e.b));
         chk("done", 32'(done), 32'(e.dn));
         // PWM: period of 256 clocks from reset; duty adopted at each boundary.
         if (!r) begin
            n = 0; act = 0; ep = 0;
         end else begin
            n++;
            prev = act;
            if (((n - 1) % 256) == 255) act = dprev;
            ep = (((n - 1) % 256) < prev) ? 1 : 0;
         end
         chk("pwm_out", 32'(pwm_out), 32'(ep));
         dprev = e.d;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      run(0, 1, 0, 0, 1, -1, -1, 1'b0);     // full triangle
      run(3, 100, 0, 0, 1, -1, -1, 1'b0);   // saturation 100,200,255 / 155,55,0
      run(0, 51, 3, 2, 0, 56, -1, 1'b0);    // dwell, infinite, stopped after 3 cycles
      run(1, 10, 0, 0, 1, 25, -1, 1'b1);    // stop at duty 120 with simultaneous start
      start = 1'b1; stop = 1'b1;            // start+stop while idle: ignored
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      run(299, 64, 0, 0, 1, -1, -1, 1'b0);  // mid-period duty changes 64->128->192
      run(0, 128, 5, 0, 1, -1, 4, 1'b0);    // reset while in HOLD_HI
      run(0, 0, 1, 1, 2, -1, -1, 1'b0);     // step 0 acts as 1
      for (int k = 0; k < 6; k++) begin
         run(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(1, 2)), (k % 2 == 1) ? -2 : -1, -1, 1'b0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
